// File: rtl/v_iota_mask.sv
// ============================================================================
// Module   : v_iota_mask
// Brief    : Mask-to-vector expander (viota.m): packed exclusive prefix counts
//            of set mask bits, with a running base carried across mask words.
//            Optional VIOTA_VID_EN adds in_vid, forcing the mask to all ones.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module v_iota_mask #(
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int DATA_WIDTH_BITS = 6
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [REQ_DATA_WIDTH-1:0]  in_m0,
    input  logic [1:0]                 in_sew,
    input  logic                       in_start,
`ifdef VIOTA_VID_EN
    input  logic                       in_vid,
`endif
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [RESP_DATA_WIDTH-1:0] out_vec,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_last
);

    localparam int MAX_E = RESP_DATA_WIDTH / 8;
    localparam int CNT_W = $clog2(MAX_E + 1);
    localparam logic [DATA_WIDTH_BITS:0] BEATS_SEW8 =
        (DATA_WIDTH_BITS+1)'(REQ_DATA_WIDTH / MAX_E);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    state_t                       state_q;
    logic [REQ_DATA_WIDTH-1:0]    mask_q;
    logic [1:0]                   sew_q;
    logic [RESP_DATA_WIDTH-1:0]   base_q;
    logic [DATA_WIDTH_BITS-1:0]   k_q;
    logic [RESP_DATA_WIDTH-1:0]   out_vec_q;
    logic                         out_valid_q;
    logic                         out_last_q;

    // Packs one beat: element j gets base plus the count of set bits below j.
    function automatic logic [RESP_DATA_WIDTH-1:0] pack_beat(
        input logic [MAX_E-1:0]           m,
        input logic [RESP_DATA_WIDTH-1:0] b,
        input logic [1:0]                 s
    );
        logic [RESP_DATA_WIDTH-1:0] r;
        logic [RESP_DATA_WIDTH-1:0] acc;
        r   = '0;
        acc = b;
        case (s)
            2'd0: for (int j = 0; j < RESP_DATA_WIDTH/8; j++) begin
                r[j*8 +: 8] = acc[7:0];
                acc = acc + RESP_DATA_WIDTH'(m[j]);
            end
            2'd1: for (int j = 0; j < RESP_DATA_WIDTH/16; j++) begin
                r[j*16 +: 16] = acc[15:0];
                acc = acc + RESP_DATA_WIDTH'(m[j]);
            end
            2'd2: for (int j = 0; j < RESP_DATA_WIDTH/32; j++) begin
                r[j*32 +: 32] = acc[31:0];
                acc = acc + RESP_DATA_WIDTH'(m[j]);
            end
            default: r = acc;
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] beat_pop(
        input logic [MAX_E-1:0] m,
        input logic [1:0]       s
    );
        logic [CNT_W-1:0] c;
        c = '0;
        for (int j = 0; j < MAX_E; j++) begin
            if (j < (MAX_E >> s)) begin
                c = c + CNT_W'(m[j]);
            end
        end
        return c;
    endfunction

    logic [REQ_DATA_WIDTH-1:0]  mask_acc_d;
    logic [RESP_DATA_WIDTH-1:0] base_acc_d;
    logic [RESP_DATA_WIDTH-1:0] vec_acc_d;
    logic [CNT_W-1:0]           elems;
    logic [RESP_DATA_WIDTH-1:0] base_nxt_d;
    logic [REQ_DATA_WIDTH-1:0]  mask_nxt_d;
    logic [RESP_DATA_WIDTH-1:0] vec_nxt_d;
    logic [DATA_WIDTH_BITS-1:0] k_nxt_d;
    logic [DATA_WIDTH_BITS-1:0] last_idx;

`ifdef VIOTA_VID_EN
    assign mask_acc_d = in_vid ? {REQ_DATA_WIDTH{1'b1}} : in_m0;
`else
    assign mask_acc_d = in_m0;
`endif

    assign base_acc_d = in_start ? '0 : base_q;
    assign vec_acc_d  = pack_beat(mask_acc_d[MAX_E-1:0], base_acc_d, in_sew);

    // The shift register always holds the bits of the beat on the output.
    assign elems      = CNT_W'(MAX_E) >> sew_q;
    assign base_nxt_d = base_q + RESP_DATA_WIDTH'(beat_pop(mask_q[MAX_E-1:0], sew_q));
    assign mask_nxt_d = mask_q >> elems;
    assign vec_nxt_d  = pack_beat(mask_nxt_d[MAX_E-1:0], base_nxt_d, sew_q);
    assign k_nxt_d    = k_q + DATA_WIDTH_BITS'(1);
    assign last_idx   = DATA_WIDTH_BITS'((BEATS_SEW8 << sew_q) - (DATA_WIDTH_BITS+1)'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            sew_q       <= '0;
            base_q      <= '0;
            k_q         <= '0;
            out_vec_q   <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        mask_q      <= mask_acc_d;
                        sew_q       <= in_sew;
                        base_q      <= base_acc_d;
                        k_q         <= '0;
                        out_vec_q   <= vec_acc_d;
                        out_valid_q <= 1'b1;
                        out_last_q  <= 1'b0;
                        state_q     <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        base_q <= base_nxt_d;
                        if (k_q == last_idx) begin
                            k_q         <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            state_q     <= S_IDLE;
                        end else begin
                            mask_q     <= mask_nxt_d;
                            k_q        <= k_nxt_d;
                            out_vec_q  <= vec_nxt_d;
                            out_last_q <= (k_nxt_d == last_idx);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_vec   = out_vec_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule

`default_nettype wire

// File: tb/tb_v_iota_mask.sv
// ============================================================================
// Module   : tb_v_iota_mask
// Brief    : Scoreboard bench for v_iota_mask with a global-index reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_v_iota_mask;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_m0;
    logic [1:0]  in_sew;
    logic        in_start;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_vec;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;
`ifdef VIOTA_VID_EN
    logic        in_vid;
`endif

    always #5 clk = ~clk;

    v_iota_mask dut (
        .clk       (clk),
        .rst       (rst),
        .in_m0     (in_m0),
        .in_sew    (in_sew),
        .in_start  (in_start),
`ifdef VIOTA_VID_EN
        .in_vid    (in_vid),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_vec   (out_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    typedef struct {
        logic [63:0] vec;
        logic        last;
    } exp_t;

    exp_t        sbq[$];
    logic [63:0] seen_vec[$];
    logic        seen_last[$];
    logic [63:0] m_base;
    bit          rand_rdy;
    int          checks   = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Element at global index n of the vector: base + ones strictly below n.
    task automatic model_push(input logic [63:0] mask, input logic [1:0] sew, input bit start);
        int          w, ne, nb, idx;
        logic [63:0] vec, cnt;
        w  = 8 << sew;
        ne = 64 / w;
        nb = 64 / ne;
        if (start) m_base = 64'd0;
        for (int k = 0; k < nb; k++) begin
            vec = 64'd0;
            for (int j = 0; j < ne; j++) begin
                idx = k * ne + j;
                cnt = m_base + 64'($countones(mask & ((64'd1 << idx) - 64'd1)));
                if (w == 64) vec = cnt;
                else vec = vec | ((cnt & ((64'd1 << w) - 64'd1)) << (j * w));
            end
            sbq.push_back('{vec, (k == nb - 1)});
        end
        m_base = m_base + 64'($countones(mask));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_word(input logic [63:0] mask, input logic [1:0] sew,
                             input bit start, input bit vid);
        int n = 0;
        while (!in_ready && n < 2000) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready_low required=in_ready_high");
            return;
        end
        in_m0    = mask;
        in_sew   = sew;
        in_start = start;
`ifdef VIOTA_VID_EN
        in_vid   = vid;
`endif
        in_valid = 1'b1;
        model_push(vid ? 64'hFFFF_FFFF_FFFF_FFFF : mask, sew, start);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(in_ready && sbq.size() == 0) && n < 2000) begin
            tick();
            n++;
        end
        if (!(in_ready && sbq.size() == 0)) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout actual=busy pending=%0d required=idle", sbq.size());
        end
    endtask

    task automatic clear_seen();
        seen_vec.delete();
        seen_last.delete();
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%h required=no_beat", out_vec);
            end else begin
                chk("beat_vec", out_vec, sbq[0].vec);
                chk("beat_last", {63'd0, out_last}, {63'd0, sbq[0].last});
                if (out_ready) begin
                    seen_vec.push_back(out_vec);
                    seen_last.push_back(out_last);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        in_m0     = 64'd0;
        in_sew    = 2'd0;
        in_start  = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
`ifdef VIOTA_VID_EN
        in_vid    = 1'b0;
`endif
        rand_rdy  = 1'b0;
        m_base    = 64'd0;
        tick();
        tick();
        rst = 1'b0;

        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_vec", out_vec, 64'd0);
        chk("reset_out_last", {63'd0, out_last}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Single SEW8 word.
        clear_seen();
        send_word(64'h0000_0000_0000_00FF, 2'd0, 1'b1, 1'b0);
        wait_idle();
        chk("sew8_nbeats", 64'(seen_vec.size()), 64'd8);
        chk("sew8_beat0", seen_vec[0], 64'h0706050403020100);
        for (int k = 1; k < 8; k++) chk("sew8_beat_k", seen_vec[k], 64'h0808080808080808);
        for (int k = 0; k < 8; k++) chk("sew8_last_k", {63'd0, seen_last[k]}, (k == 7) ? 64'd1 : 64'd0);

        // Continuation keeps the base of 8.
        clear_seen();
        send_word(64'h1, 2'd0, 1'b0, 1'b0);
        wait_idle();
        chk("cont_beat0", seen_vec[0], 64'h0909090909090908);

        // SEW64 with exact cycle timing.
        clear_seen();
        send_word(64'h5, 2'd3, 1'b1, 1'b0);
        for (int i = 0; i < 63; i++) tick();
        chk("sew64_last_present", {63'd0, out_last}, 64'd1);
        chk("sew64_busy", {63'd0, in_ready}, 64'd0);
        tick();
        chk("sew64_ready_after", {63'd0, in_ready}, 64'd1);
        chk("sew64_valid_after", {63'd0, out_valid}, 64'd0);
        chk("sew64_beat0", seen_vec[0], 64'd0);
        chk("sew64_beat1", seen_vec[1], 64'd1);
        chk("sew64_beat2", seen_vec[2], 64'd1);
        chk("sew64_beat3", seen_vec[3], 64'd2);
        chk("sew64_beat63", seen_vec[63], 64'd2);

        // Backpressure on beat 2 for three cycles.
        send_word(64'hFFFF, 2'd1, 1'b1, 1'b0);
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_valid_held", {63'd0, out_valid}, 64'd1);
            chk("bp_vec_held", out_vec, 64'h000B000A00090008);
            tick();
        end
        chk("bp_vec_held_end", out_vec, 64'h000B000A00090008);
        out_ready = 1'b1;
        tick();
        chk("bp_beat3", out_vec, 64'h000F000E000D000C);
        wait_idle();

        // in_valid during EMIT must not be accepted.
        send_word({$urandom, $urandom}, 2'd1, 1'b0, 1'b0);
        in_m0    = 64'hDEAD_BEEF_0123_4567;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("emit_in_ready_low", {63'd0, in_ready}, 64'd0);
            tick();
        end
        in_valid = 1'b0;
        wait_idle();

        // Base wraps modulo 2^8 after 256 counted ones.
        clear_seen();
        for (int w = 0; w < 5; w++) send_word(64'hFFFF_FFFF_FFFF_FFFF, 2'd0, (w == 0), 1'b0);
        wait_idle();
        chk("wrap_word5_beat0", seen_vec[32], 64'h0706050403020100);

        // Reset during beat 3 of a word.
        send_word({$urandom, $urandom}, 2'd0, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        rst = 1'b1;
        sbq.delete();
        tick();
        rst = 1'b0;
        m_base = 64'd0;
        chk("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
        clear_seen();
        send_word(64'h1, 2'd0, 1'b0, 1'b0);
        wait_idle();
        chk("rst_mid_beat0", seen_vec[0], 64'h0101010101010100);

        // Randomized words with random downstream stalls.
        rand_rdy = 1'b1;
        for (int w = 0; w < 40; w++) begin
            logic [63:0] m;
            case ($urandom_range(0, 3))
                0:       m = 64'hFFFF_FFFF_FFFF_FFFF;
                1:       m = {$urandom, $urandom} & {$urandom, $urandom};
                default: m = {$urandom, $urandom};
            endcase
            send_word(m, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), 1'b0);
        end
        rand_rdy  = 1'b0;
        out_ready = 1'b1;
        wait_idle();
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/v_iota_mask.md
# v_iota_mask

Mask-to-vector expander for the vALU: the inverse-direction companion to the mask population counter. It takes a 64-bit mask word and emits, over several output beats, the packed per-element exclusive prefix counts of set mask bits (viota.m semantics). A running base count carries across consecutive mask words so that long vectors are handled as a stream. The block sits between the mask register read port and the vALU result writeback path.

## Interface
- REQ_DATA_WIDTH, 64, mask word width (mask bits per input beat)
- RESP_DATA_WIDTH, 64, output data width (packed elements per beat)
- DATA_WIDTH_BITS, 6, log2(REQ_DATA_WIDTH); width of the beat index
- clk  in  1  clock
- rst  in  1  reset: synchronous, active-high
- in_m0  in  REQ_DATA_WIDTH  mask word; bit i belongs to element i of this word
- in_sew  in  2  element width: 0=8b, 1=16b, 2=32b, 3=64b
- in_start  in  1  first word of a vector; clears the running base to 0
- in_valid  in  1  input word valid
- in_ready  out  1  block can accept a word (high only in IDLE)
- out_vec  out  RESP_DATA_WIDTH  packed prefix counts; element 0 in the LSBs
- out_valid  out  1  out_vec valid
- out_ready  in  1  downstream accepts the beat
- out_last  out  1  final beat of the current mask word

## Operation
- E = RESP_DATA_WIDTH/SEW elements per beat (8/4/2/1); B = REQ_DATA_WIDTH/E beats per word (8/16/32/64).
- States: IDLE, EMIT.
- IDLE: in_ready=1. On in_valid&&in_ready: latch the mask into the shift register, latch sew, set base to 0 if in_start (otherwise keep it), set k=0, go to EMIT.
- EMIT: beat k element j = base + popcount(mask[k*E .. k*E+j-1]), truncated to SEW bits (modulo 2^SEW wrap).
- On out_valid&&out_ready: base += popcount(mask[k*E +: E]), mask shifts right by E, and k increments. If k==B-1, go to IDLE instead.
- base is RESP_DATA_WIDTH wide. It wraps at 2^64 and is truncated only per element.
- in_sew and in_start are sampled only at accept. Changes during EMIT are ignored.
- There is no overlap between words: the next word is accepted only once the block is back in IDLE.

## Timing
- Reset values: out_valid=0, out_vec=0, out_last=0, in_ready=1, base=0, k=0, state IDLE.
- Latency: out_valid rises the cycle after the accept and carries beat 0.
- Each following beat is presented the cycle after the previous beat's handshake.
- With out_ready held high, one beat per cycle: a word occupies B cycles, plus 1 cycle back in IDLE before the next accept.
- out_vec, out_last and out_valid are registered. They hold stable while out_valid&&!out_ready. base and k do not advance while stalled.
- out_last=1 only on beat B-1, qualified by out_valid.
- rst during EMIT aborts the word. The next cycle shows reset values, and the partial word is lost.
- in_valid during EMIT is ignored: in_ready=0, no accept.

## Configuration
- VIOTA_VID_EN defined: adds input in_vid (1 bit, sampled at accept). When in_vid=1, the latched mask is forced to all ones (vid.v semantics: element index). When in_vid=0, behaviour is unchanged.
- VIOTA_VID_EN undefined: no in_vid port, and the mask is always used as given.

## Test plan
- Single word, SEW8: in_start=1, mask=0x00000000000000FF → 8 beats. Beat 0 = 0x0706050403020100. Beats 1–7 = 0x0808080808080808. out_last only on beat 7.
- Continuation: the previous test followed by SEW8, in_start=0, mask=0x1 → beat 0 = 0x0909090909090908.
- SEW64: in_start=1, mask=0x5 → 64 beats: beat0=0, beat1=1, beat2=1, beats 3–63=2. Then in_ready=1 one cycle after the last handshake.
- Backpressure: SEW16, mask=0xFFFF, out_ready low for 3 cycles at beat 2 → out_vec=0x000B000A00090008 and out_valid held for all 3 cycles, then beat 3 = 0x000F000E000D000C.
- Wrap: SEW8, all-ones mask for 5 words, in_start on word 1 only → word 5 beat 0 = 0x0706050403020100 (count 256 wraps to 0).
- Reset mid-word: assert rst at SEW8 beat 3 → next cycle out_valid=0, in_ready=1. A new in_start=0 word with mask=0x1 gives beat 0 = 0x0101010101010100 (base cleared by reset).
